fsmv_block_seq: RTL

Parametrised successor to the convolution control FSM. It sequences column loading into image memory and block-wise read-out to N_CONV parallel convolvers. It generates delayed write-back addresses for results and supports downstream back-pressure. It sits between the host load interface, the dual-port image RAM and the convolver array.

---
 rtl/fsmv_block_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fsmv_block_seq.sv
// fsmv_block_seq: column load and block-wise read-out sequencer
// for N_CONV parallel convolvers sharing one dual-port image RAM.
module fsmv_block_seq #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int N_CONV     = 4,
  parameter int RD_LAT     = 1,
  parameter int CONV_LAT   = 2
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_valid,
  input  logic                  i_SoP,
  input  logic [NB_IMAGE-1:0]   i_imgLength,
  input  logic                  i_ready,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  output logic                  o_fsm2convVld,
  output logic                  o_changeBlock,
  output logic                  o_EoP,
  output logic                  o_loadDone,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int PIPE_LAT = RD_LAT + CONV_LAT;
  localparam logic [31:0] AMAX = 32'((64'd1 << NB_ADDRESS) - 64'd1);
  localparam logic [PIPE_LAT-1:0] TOP = PIPE_LAT'(1) << (PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN
  } state_t;

  state_t                state;
  logic [NB_ADDRESS-1:0] l_q;
  logic [NB_ADDRESS-1:0] col;
  logic [NB_ADDRESS-1:0] row_base;
  logic [NB_ADDRESS-1:0] rd_add;
  logic                  issue;
  logic                  last_col;
  logic [PIPE_LAT-1:0]   sv;
  logic [PIPE_LAT-1:0]   sl;
  logic [NB_ADDRESS-1:0] sa [PIPE_LAT];
  logic                  load_done;
  logic                  eop;
  logic                  busy;
  logic                  err;

  logic len_bad;
  logic col_end;
  logic final_blk;
  logic pend;

  assign len_bad   = 32'(i_imgLength) > AMAX;
  assign col_end   = (col == l_q);
  assign final_blk = (32'(row_base) + 32'(N_CONV)) > 32'(l_q);
  // Anything still short of the write-back output stage keeps DRAIN alive.
  assign pend      = issue | (|(sv & ~TOP));

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      l_q       <= '0;
      col       <= '0;
      row_base  <= '0;
      rd_add    <= '0;
      issue     <= 1'b0;
      last_col  <= 1'b0;
      sv        <= '0;
      sl        <= '0;
      for (int k = 0; k < PIPE_LAT; k++) sa[k] <= '0;
      load_done <= 1'b0;
      eop       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      eop      <= 1'b0;
      issue    <= 1'b0;
      last_col <= 1'b0;
      sv       <= (sv << 1) | PIPE_LAT'(issue);
      sl       <= (sl << 1) | PIPE_LAT'(issue & last_col);
      if (state == RUN || state == DRAIN) begin
        for (int k = PIPE_LAT - 1; k > 0; k--) sa[k] <= sa[k-1];
        sa[0] <= rd_add;
      end
      case (state)
        IDLE: begin
          if (i_load) begin
            l_q       <= NB_ADDRESS'(i_imgLength);
            load_done <= 1'b0;
            if (len_bad) err <= 1'b1;
            else state <= LOAD;
          end else if (i_SoP && load_done) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (!i_load) begin
            state            <= IDLE;
            sa[PIPE_LAT-1]   <= '0;
          end else if (i_valid && !load_done) begin
            if (sa[PIPE_LAT-1] == l_q) load_done <= 1'b1;
            else sa[PIPE_LAT-1] <= sa[PIPE_LAT-1] + 1'b1;
          end
        end
        RUN: begin
          if (i_ready) begin
            issue    <= 1'b1;
            rd_add   <= col;
            last_col <= col_end;
            if (col_end) begin
              col <= '0;
              if (final_blk) state <= DRAIN;
              else row_base <= row_base + NB_ADDRESS'(N_CONV);
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!pend) begin
            state          <= IDLE;
            busy           <= 1'b0;
            eop            <= 1'b1;
            load_done      <= 1'b0;
            rd_add         <= '0;
            row_base       <= '0;
            sa[PIPE_LAT-1] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_writeAdd    = sa[PIPE_LAT-1];
  assign o_readAdd     = rd_add;
  assign o_fsm2convVld = sv[RD_LAT-1];
  assign o_changeBlock = sl[RD_LAT-1];
  assign o_EoP         = eop;
  assign o_loadDone    = load_done;
  assign o_busy        = busy;
  assign o_err         = err;

endmodule
